// File: rtl/stream_packer.sv
// stream_packer: packs PACK_NUM words per beat with burst last tagging, flush and idle timeout (in_*: narrow words, out_*: wide beat with keep/last)
module stream_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_NUM   = 4,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_WIDTH-1:0]          in_data_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DATA_WIDTH*PACK_NUM-1:0] out_data_o,
  output logic [PACK_NUM-1:0]            out_keep_o,
  output logic                           out_last_o
);
  localparam int LW = $clog2(PACK_NUM);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {FILL, SEND} state_t;
  state_t                         state_q, state_d;
  logic [LW-1:0]                  lane_q, lane_d;
  logic [BW-1:0]                  beat_q, beat_d;
  logic [TW-1:0]                  idle_q, idle_d;
  logic [DATA_WIDTH*PACK_NUM-1:0] data_q, data_d;
  logic [PACK_NUM-1:0]            keep_q, keep_d, mask;
  logic                           last_q, last_d;
  logic                           accept, timed_out, full;
  logic [LW:0]                    cnt_n;
  assign in_ready_o  = !rst && (state_q == FILL || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = state_q == SEND;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;
  assign out_last_o  = last_q;
  assign cnt_n       = {1'b0, lane_q} + {{LW{1'b0}}, accept};
  assign full        = cnt_n == (LW + 1)'(PACK_NUM);
  assign timed_out   = TIMEOUT != 0 && !accept && lane_q != '0 && idle_q == TW'(TIMEOUT - 1);
  always_comb begin
    mask = '0;
    for (int k = 0; k < PACK_NUM; k++) mask[k] = (LW + 1)'(k) < cnt_n;
  end
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (state_q == FILL) begin
      if (accept) data_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
      lane_d = cnt_n[LW-1:0];
      idle_d = (accept || lane_q == '0) ? '0 : idle_q + 1'b1;
      if (full || (flush_i && lane_q != '0) || timed_out) begin
        state_d = SEND;
        lane_d  = '0;
        idle_d  = '0;
        keep_d  = full ? '1 : mask;
        last_d  = !full || beat_q == BW'(BURST_LEN - 1);
      end
    end else if (out_ready_i) begin
      state_d = FILL;
      data_d  = accept ? (DATA_WIDTH*PACK_NUM)'(in_data_i) : '0;
      lane_d  = accept ? LW'(1) : '0;
      idle_d  = '0;
      keep_d  = '0;
      last_d  = 1'b0;
      beat_d  = last_q ? '0 : beat_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      lane_q  <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end
endmodule
